// File: rtl/gate_share_arbiter_if.sv
// gate_share_arbiter_if: requester, shared-unit and response signals of gate_share_arbiter
interface gate_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req, req_a, req_b, gnt;
  logic unit_a, unit_b, unit_q, rsp_valid, rsp_data, busy;
  logic [ID_W-1:0] rsp_id;
  logic [7:0] op_count;
  modport master(output req, req_a, req_b, unit_q,
                 input gnt, unit_a, unit_b, rsp_valid, rsp_id, rsp_data, busy, op_count);
  modport slave(input req, req_a, req_b, unit_q,
                output gnt, unit_a, unit_b, rsp_valid, rsp_id, rsp_data, busy, op_count);
endinterface

// File: rtl/gate_share_arbiter.sv
// gate_share_arbiter: round-robin sharing of one flopped gate unit; GATE_ARB_FIXED_PRIO_EN selects fixed priority
module gate_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst,
  gate_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic [ID_W-1:0] cur_id, win, idx;
`ifndef GATE_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0] ptr;
`endif
  assign bus.busy = state != IDLE;
  // descending scan so the nearest candidate is the last one written
  always_comb begin
    win = '0;
    idx = '0;
`ifdef GATE_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'(i);
      if (bus.req[idx]) win = idx;
    end
`else
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (bus.req[idx]) win = idx;
    end
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bus.gnt <= '0;
      bus.unit_a <= 1'b0;
      bus.unit_b <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_data <= 1'b0;
      bus.op_count <= 8'd0;
      cur_id <= '0;
`ifndef GATE_ARB_FIXED_PRIO_EN
      ptr <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          bus.gnt <= '0;
          if (|bus.req) begin
            state <= ISSUE;
            bus.gnt <= NUM_REQ'(1) << win;
            bus.unit_a <= bus.req_a[win];
            bus.unit_b <= bus.req_b[win];
            cur_id <= win;
`ifndef GATE_ARB_FIXED_PRIO_EN
            ptr <= win;
`endif
          end
        end
        ISSUE: begin
          bus.gnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_id <= cur_id;
          bus.rsp_data <= bus.unit_q;
          bus.op_count <= bus.op_count + 8'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_share_arbiter.sv
// tb_gate_share_arbiter: vector table, scoreboard and corner sequences for gate_share_arbiter
module tb_gate_share_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gate_share_arbiter_if #(.NUM_REQ(N)) bus();
  gate_share_arbiter #(.NUM_REQ(N)) dut(.clk(clk), .rst(rst), .bus(bus));
  // shared unit is an AND gate with a register on its output
  always @(posedge clk) bus.unit_q <= bus.unit_a & bus.unit_b;
  int checks = 0, failures = 0, cyc = 0, mptr = N - 1, w;
  typedef struct {int id; bit data; int c;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [N-1:0] pr = '0, pa = '0, pb = '0;
  typedef struct {logic [N-1:0] req, a, b; int id; bit data;} vec_t;
  vec_t tv[9];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic int pick(input int p, input logic [N-1:0] r);
    int res = 0;
    bit found = 0;
`ifdef GATE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (!found && r[i]) begin res = i; found = 1; end
`else
    for (int k = 1; k <= N; k++) if (!found && r[(p + k) % N]) begin res = (p + k) % N; found = 1; end
`endif
    return res;
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      mptr = N - 1;
    end else begin
      if (|bus.gnt) begin
        w = pick(mptr, pr);
        chk("sb_gnt", 32'(bus.gnt), 1 << w);
        q.push_back('{w, pa[w] & pb[w], cyc});
        mptr = w;
      end
      if (bus.rsp_valid) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_spurious rsp_valid with no op outstanding at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("sb_id", 32'(bus.rsp_id), e.id);
          chk("sb_data", 32'(bus.rsp_data), 32'(e.data));
          chk("sb_latency", cyc - e.c, 2);
        end
      end
    end
    pr = bus.req;
    pa = bus.req_a;
    pb = bus.req_b;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int id, n, k, last;
    bit d;
    tv[0] = '{4'b1111, 4'b0001, 4'b0001, 0, 1};
    tv[1] = '{4'b0100, 4'b0100, 4'b0100, 2, 1};
    tv[2] = '{4'b1011, 4'b1111, 4'b0111, 3, 0};
    tv[3] = '{4'b1011, 4'b0001, 4'b0001, 0, 1};
    tv[4] = '{4'b1011, 4'b0010, 4'b0000, 1, 0};
    tv[5] = '{4'b1001, 4'b1000, 4'b1000, 3, 1};
    tv[6] = '{4'b0110, 4'b0100, 4'b0110, 1, 0};
    tv[7] = '{4'b0110, 4'b0100, 4'b0110, 2, 1};
    tv[8] = '{4'b0001, 4'b1110, 4'b1111, 0, 0};
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (2) @(posedge clk);
    #2 bus.req = '1;
    tick();
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_op_count", 32'(bus.op_count), 0);
    #1 rst = 1'b0;
    tick();
    chk("first_gnt", 32'(bus.gnt), 1);
    chk("first_busy", 32'(bus.busy), 1);
    #1 bus.req = '0;
    tick();
    chk("issue_gnt", 32'(bus.gnt), 0);
    #1 rst = 1'b1;
    tick();
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("midrst_op_count", 32'(bus.op_count), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    #1 rst = 1'b0;
    tick();
    chk("midrst_rsp_valid2", 32'(bus.rsp_valid), 0);
    #1;
    foreach (tv[i]) begin
      id = tv[i].id;
      d = tv[i].data;
`ifdef GATE_ARB_FIXED_PRIO_EN
      id = pick(0, tv[i].req);
      d = tv[i].a[id] & tv[i].b[id];
`endif
      bus.req = tv[i].req;
      bus.req_a = tv[i].a;
      bus.req_b = tv[i].b;
      tick();
      chk("tv_gnt", 32'(bus.gnt), 1 << id);
      chk("tv_unit_a", 32'(bus.unit_a), 32'(tv[i].a[id]));
      chk("tv_busy", 32'(bus.busy), 1);
      #1 bus.req = '0;
      bus.req_a = ~tv[i].a;
      bus.req_b = ~tv[i].b;
      tick();
      chk("tv_gnt_clear", 32'(bus.gnt), 0);
      tick();
      chk("tv_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("tv_rsp_id", 32'(bus.rsp_id), id);
      chk("tv_rsp_data", 32'(bus.rsp_data), 32'(d));
      chk("tv_busy_done", 32'(bus.busy), 0);
      #1;
    end
    chk("tv_op_count", 32'(bus.op_count), 9);
    rst = 1'b1;
    tick();
    #1 rst = 1'b0;
    bus.req = '1;
    bus.req_a = '1;
    bus.req_b = 4'b0101;
    n = 0;
    k = 0;
    last = -1;
    for (int c = 0; c < 900 && n < 256; c++) begin
      tick();
      if (|bus.gnt) begin
`ifdef GATE_ARB_FIXED_PRIO_EN
        chk("rr_gnt", 32'(bus.gnt), 1);
`else
        chk("rr_gnt", 32'(bus.gnt), 1 << (k % N));
`endif
        k++;
      end
      if (bus.rsp_valid) begin
        if (last >= 0) chk("rr_gap", c - last, 3);
        last = c;
        n++;
        if (n == 12) chk("rr_op_count12", 32'(bus.op_count), 12);
      end
    end
    chk("wrap_rsp_count", n, 256);
    chk("wrap_op_count", 32'(bus.op_count), 0);
    bus.req = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gate_share_arbiter.md
# gate_share_arbiter

Round-robin arbiter and sequencer that shares one registered two-input gate unit (inputs a/b, flopped output) among NUM_REQ requesters. It latches the winning requester's operands onto the unit and waits the unit's one-cycle register latency. It then returns the result with the requester ID on a single response port. It sits between the requesting blocks and the shared gate instance.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8
- ID_W, $clog2(NUM_REQ), width of requester ID
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- req_a  in  NUM_REQ  per-requester operand a
- req_b  in  NUM_REQ  per-requester operand b
- gnt  out  NUM_REQ  one-hot grant, registered, one-cycle pulse
- unit_a  out  1  registered operand a to shared unit
- unit_b  out  1  registered operand b to shared unit
- unit_q  in  1  shared unit's flopped output
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  ID_W  index of requester owning rsp_data
- rsp_data  out  1  captured unit_q
- busy  out  1  high whenever state is not IDLE
- op_count  out  8  completed-operation counter, wraps 255 -> 0

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE with any req bit high:
  - Select the winner and go to ISSUE.
  - Register gnt = onehot(winner), unit_a = req_a[winner], unit_b = req_b[winner].
  - Set ptr = winner and cur_id = winner.
- IDLE with req all zero: stay in IDLE; gnt = 0; unit_a/unit_b hold their values.
- ISSUE → WAIT unconditionally. gnt clears to 0. unit_a/unit_b hold so the unit samples them at this edge.
- WAIT → IDLE unconditionally:
  - rsp_data <= unit_q, rsp_id <= cur_id, rsp_valid <= 1.
  - op_count increments.
- rsp_valid, rsp_id and rsp_data are registered. rsp_valid is 1 only in the cycle after the WAIT edge.
- rsp_id and rsp_data hold their last value until the next response.
- Round-robin order: search indices ptr+1, ptr+2, … modulo NUM_REQ. The first requester with req high wins.
- After reset, ptr = NUM_REQ-1, so index 0 has first priority.
- req is level-sensitive and sampled only in IDLE. A requester keeping req high is re-arbitrated every op.
- Operands are captured only at grant. Later changes to req_a/req_b do not affect an op already in flight.
- Reset values:
  - state = IDLE, ptr = NUM_REQ-1
  - gnt = 0, unit_a = 0, unit_b = 0
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0
  - busy = 0, op_count = 0
- Reset asserted mid-operation aborts the op immediately. No rsp_valid is produced for it, and op_count does not count it.

## Timing
- Edge E0 (IDLE, req seen): gnt, unit_a/b registered and visible after E0. busy = 1.
- Edge E1 (ISSUE): the unit samples unit_a/b; unit_q is valid after E1. gnt returns to 0.
- Edge E2 (WAIT): response is registered. rsp_valid is high from E2 to E3. busy = 0 after E2.
- Edge E3: earliest next grant.
- Latency is 2 clocks from grant to rsp_valid; throughput is one op per 3 clocks.
- busy is combinational from state.
- A requester must drop req before E3 unless it wants another op. A req still high at E3 re-enters arbitration.
- Simultaneous requests: exactly one gnt bit is set, and unserved requesters wait. With all NUM_REQ requesting continuously, each is served once every NUM_REQ ops.
- op_count wraps silently from 255 to 0; there is no saturation or flag.

## Configuration
- GATE_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority; the lowest index with req high always wins. ptr is unused and may be removed.
  - Undefined (default): round-robin as described above.
- All other behaviour and timing are identical in both builds.

## Test plan
- Reset: hold rst, drive req = 4'b1111 → gnt = 0, rsp_valid = 0, busy = 0, op_count = 0. Release rst → first gnt = 4'b0001 at the next edge.
- Single op: req[2] = 1, a = 1, b = 1, unit = AND → gnt = 4'b0100 for one cycle. Two edges later, rsp_valid = 1, rsp_id = 2, rsp_data = 1, op_count = 1.
- Round-robin: req = 4'b1111 held for 12 ops → grant order 0,1,2,3,0,1,…; rsp_id follows the same order; op_count = 12. With GATE_ARB_FIXED_PRIO_EN defined, all 12 grants go to 0.
- Operand capture: grant req[1] with a = 1, b = 1, then flip req_a[1] = 0 in ISSUE → rsp_data = 1.
- Reset mid-op: assert rst in WAIT → no rsp_valid, op_count unchanged, state = IDLE, ptr = NUM_REQ-1.
- Counter wrap: run 256 ops → op_count returns to 0. rsp_valid count equals 256 and no gaps other than the 3-cycle cadence.
